dev_reshuffler_ctrl: RTL and testbench

Stream sequencer that drives the data reshuffler through a configured number of transfers. It gates the upstream valid/ready stream into the reshuffler and the reshuffler's output stream towards the consumer, and counts handshakes on both sides. It also limits in-flight transfers so the reshuffler's single output register is never overwritten before it is consumed, and reports busy/done to the host CSR layer. Data buses bypass this block; only handshakes and control pass through it.

---
 rtl/dev_reshuffler_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dev_reshuffler_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dev_reshuffler_ctrl.sv
// ---- dev_reshuffler_ctrl: handshake sequencer and in-flight limiter for the reshuffler ----
// ---- Optional busy-cycle counter: DEV_RESHUFFLER_CTRL_PERF_EN | Revision 1.0 ----
`default_nettype none

module dev_reshuffler_ctrl #(
  parameter int unsigned CntWidth       = 16,
  parameter int unsigned MaxOutstanding = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [CntWidth-1:0] len_i,
  input  logic                clear_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic                src_valid_i,
  output logic                src_ready_o,
  output logic                dp_valid_o,
  input  logic                dp_ready_i,
  input  logic                dp_out_valid_i,
  output logic                dp_out_ready_o,
  output logic                dst_valid_o,
  input  logic                dst_ready_i,
  output logic [CntWidth-1:0] in_cnt_o,
  output logic [CntWidth-1:0] out_cnt_o
`ifdef DEV_RESHUFFLER_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_cycles_o
`endif
);

  localparam int unsigned         OutW   = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0]     MaxOut = OutW'(MaxOutstanding);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] len_q, len_d;
  logic [CntWidth-1:0] in_cnt_q, in_cnt_d;
  logic [CntWidth-1:0] out_cnt_q, out_cnt_d;
  logic [OutW-1:0]     outst_q, outst_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic                in_en, out_en, in_hs, out_hs;
  logic [CntWidth-1:0] in_cnt_inc, out_cnt_inc;

  // Handshake gating looks only at registered state so start/clear never reach these outputs.
  assign in_en  = (state_q == StRun) && (in_cnt_q < len_q) && (outst_q < MaxOut);
  assign out_en = ((state_q == StRun) || (state_q == StDrain)) && (out_cnt_q < in_cnt_q);

  assign dp_valid_o     = src_valid_i & in_en;
  assign src_ready_o    = dp_ready_i & in_en;
  assign dst_valid_o    = dp_out_valid_i & out_en;
  assign dp_out_ready_o = dst_ready_i & out_en;

  assign in_hs       = dp_valid_o & dp_ready_i;
  assign out_hs      = dp_out_valid_i & dp_out_ready_o;
  assign in_cnt_inc  = in_cnt_q + 1'b1;
  assign out_cnt_inc = out_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    outst_d   = outst_q;
    done_d    = 1'b0;
    busy_d    = busy_q;

    if (clear_i) begin
      state_d = StIdle;
      outst_d = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_d = 1'b1;
            end else begin
              state_d   = StRun;
              len_d     = len_i;
              in_cnt_d  = '0;
              out_cnt_d = '0;
              outst_d   = '0;
              busy_d    = 1'b1;
            end
          end
        end
        StRun, StDrain: begin
          if (in_hs)  in_cnt_d  = in_cnt_inc;
          if (out_hs) out_cnt_d = out_cnt_inc;
          if (in_hs && !out_hs)      outst_d = outst_q + 1'b1;
          else if (!in_hs && out_hs) outst_d = outst_q - 1'b1;

          if (state_q == StRun) begin
            if (in_hs && (in_cnt_inc == len_q)) state_d = StDrain;
          end else if (out_hs && (out_cnt_inc == len_q)) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      outst_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      outst_q   <= outst_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign in_cnt_o  = in_cnt_q;
  assign out_cnt_o = out_cnt_q;

`ifdef DEV_RESHUFFLER_CTRL_PERF_EN
  logic [31:0] perf_q;
  logic        start_acc;

  assign start_acc = (state_q == StIdle) && start_i && !clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (start_acc) begin
      perf_q <= '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dev_reshuffler_ctrl.sv
// Bench for dev_reshuffler_ctrl: directed vector table, corner sequences and randomized
// stimulus checked against a job-level reference model.
`default_nettype none

module tb_dev_reshuffler_ctrl;

  localparam int MAXO = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear, srcv, dpr, dov, dstr;
  logic [15:0] len;
  logic        busy_o, done_o, src_ready_o, dp_valid_o, dp_out_ready_o, dst_valid_o;
  logic [15:0] in_cnt_o, out_cnt_o;
`ifdef DEV_RESHUFFLER_CTRL_PERF_EN
  logic [31:0] perf_cycles_o;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: a job is a count of accepted and delivered items against a length.
  bit     m_active, m_done, m_done_busy;
  int     m_len, m_in, m_out;
  longint m_perf;

  always #5 clk = ~clk;

  dev_reshuffler_ctrl #(.CntWidth(16), .MaxOutstanding(MAXO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .len_i          (len),
    .clear_i        (clear),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .src_valid_i    (srcv),
    .src_ready_o    (src_ready_o),
    .dp_valid_o     (dp_valid_o),
    .dp_ready_i     (dpr),
    .dp_out_valid_i (dov),
    .dp_out_ready_o (dp_out_ready_o),
    .dst_valid_o    (dst_valid_o),
    .dst_ready_i    (dstr),
    .in_cnt_o       (in_cnt_o),
    .out_cnt_o      (out_cnt_o)
`ifdef DEV_RESHUFFLER_CTRL_PERF_EN
    ,
    .perf_cycles_o  (perf_cycles_o)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_done_busy = 0;
    m_len = 0; m_in = 0; m_out = 0; m_perf = 0;
  endtask

  // Called at a falling edge: apply inputs and let combinational outputs settle.
  task automatic drive(input logic st, input logic [15:0] ln, input logic clr,
                       input logic sv, input logic dr, input logic ov, input logic sr);
    start = st; len = ln; clear = clr; srcv = sv; dpr = dr; dov = ov; dstr = sr;
    #1;
  endtask

  // Compare every output against the model, then cross one rising edge and update the model.
  task automatic adv();
    bit eb, ie, oe, ih, oh, acc;
    eb = m_active || (m_done && m_done_busy);
    ie = m_active && (m_in < m_len) && ((m_in - m_out) < MAXO);
    oe = m_active && (m_out < m_in);
    chk("busy", busy_o, eb);
    chk("done", done_o, m_done);
    chk("in_cnt", in_cnt_o, m_in);
    chk("out_cnt", out_cnt_o, m_out);
    chk("handshakes", {src_ready_o, dp_valid_o, dp_out_ready_o, dst_valid_o},
        {dpr & ie, srcv & ie, dstr & oe, dov & oe});
`ifdef DEV_RESHUFFLER_CTRL_PERF_EN
    chk("perf", perf_cycles_o, m_perf);
`endif
    ih  = srcv && dpr && ie;
    oh  = dov && dstr && oe;
    acc = start && !clear && !eb;
    @(posedge clk);
    if (acc) m_perf = 0;
    else if (eb && m_perf < 64'hFFFF_FFFF) m_perf++;
    if (clear) begin
      m_active = 0; m_done = 0; m_done_busy = 0;
    end else begin
      m_done = 0; m_done_busy = 0;
      if (acc) begin
        if (len == 0) begin
          m_done = 1;
        end else begin
          m_active = 1; m_len = len; m_in = 0; m_out = 0;
        end
      end else if (m_active) begin
        m_in  += int'(ih);
        m_out += int'(oh);
        if (m_out == m_len) begin
          m_active = 0; m_done = 1; m_done_busy = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to_idle(input logic sv, input logic dr, input logic ov, input logic sr);
    int n = 0;
    while ((m_active || m_done) && n < 200) begin
      drive(0, 16'd0, 0, sv, dr, ov, sr);
      adv();
      n++;
    end
    chk("job_timeout", (n >= 200), 0);
  endtask

  typedef struct {
    logic        st;
    logic [15:0] ln;
    logic        clr, sv, dr, ov, sr;
    logic [5:0]  flags;  // busy, done, src_ready, dp_valid, dp_out_ready, dst_valid
    logic [15:0] ein, eout;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{1, 16'd0, 0, 0, 0, 0, 0, 6'b00_0000, 16'd0, 16'd0};
    vt[1]  = '{0, 16'd0, 0, 0, 0, 0, 0, 6'b01_0000, 16'd0, 16'd0};
    vt[2]  = '{0, 16'd0, 0, 0, 0, 0, 0, 6'b00_0000, 16'd0, 16'd0};
    vt[3]  = '{1, 16'd2, 0, 1, 1, 1, 1, 6'b00_0000, 16'd0, 16'd0};
    vt[4]  = '{1, 16'd9, 0, 1, 1, 1, 1, 6'b10_1100, 16'd0, 16'd0};
    vt[5]  = '{0, 16'd0, 0, 1, 1, 1, 1, 6'b10_0011, 16'd1, 16'd0};
    vt[6]  = '{0, 16'd0, 0, 1, 1, 1, 1, 6'b10_1100, 16'd1, 16'd1};
    vt[7]  = '{0, 16'd0, 0, 1, 1, 1, 1, 6'b10_0011, 16'd2, 16'd1};
    vt[8]  = '{0, 16'd0, 0, 1, 1, 1, 1, 6'b11_0000, 16'd2, 16'd2};
    vt[9]  = '{0, 16'd0, 0, 1, 1, 1, 1, 6'b00_0000, 16'd2, 16'd2};
    vt[10] = '{1, 16'd3, 1, 1, 1, 1, 1, 6'b00_0000, 16'd2, 16'd2};
    vt[11] = '{0, 16'd0, 0, 1, 1, 1, 1, 6'b00_0000, 16'd2, 16'd2};

    rst_n = 1'b0;
    start = 0; len = '0; clear = 0; srcv = 0; dpr = 0; dov = 0; dstr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy_o, done_o, in_cnt_o, out_cnt_o}, 34'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].st, vt[i].ln, vt[i].clr, vt[i].sv, vt[i].dr, vt[i].ov, vt[i].sr);
      chk($sformatf("vec%0d", i),
          {busy_o, done_o, src_ready_o, dp_valid_o, dp_out_ready_o, dst_valid_o, in_cnt_o, out_cnt_o},
          {vt[i].flags, vt[i].ein, vt[i].eout});
      adv();
    end

    // len=4 with everything ready: alternating in/out, single done pulse
    begin
      int dones = 0;
      drive(1, 16'd4, 0, 1, 1, 1, 1); adv();
      for (int n = 0; n < 12; n++) begin
        drive(0, 16'd0, 0, 1, 1, 1, 1);
        if (done_o) dones++;
        adv();
      end
      chk("len4_counts", {in_cnt_o, out_cnt_o}, {16'd4, 16'd4});
      chk("len4_done_pulses", dones, 1);
    end

    // len=3 with the consumer stalled for 10 cycles after the first input
    drive(1, 16'd3, 0, 1, 1, 1, 0); adv();
    drive(0, 16'd0, 0, 1, 1, 1, 0); adv();
    for (int n = 0; n < 10; n++) begin
      drive(0, 16'd0, 0, 1, 1, 1, 0);
      chk("stall_no_overwrite", dp_valid_o, 0);
      adv();
    end
    run_to_idle(1, 1, 1, 1);
    drive(0, 16'd0, 0, 0, 0, 0, 0);
    chk("stall_out_cnt", out_cnt_o, 3);
    adv();

    // clear after 2 of 5 inputs
    drive(1, 16'd5, 0, 1, 1, 1, 1); adv();
    for (int n = 0; n < 10 && m_in < 2; n++) begin
      drive(0, 16'd0, 0, 1, 1, 1, 1); adv();
    end
    drive(0, 16'd0, 1, 1, 1, 1, 1); adv();
    drive(0, 16'd0, 0, 1, 1, 1, 1);
    chk("clear_idle", {busy_o, done_o, src_ready_o, dp_valid_o, dp_out_ready_o, dst_valid_o}, 6'd0);
    chk("clear_in_cnt", in_cnt_o, 2);
    adv();

    // start pulsed mid-job is ignored
    drive(1, 16'd4, 0, 1, 1, 1, 1); adv();
    drive(1, 16'd9, 0, 1, 1, 1, 1); adv();
    drive(1, 16'd9, 0, 1, 1, 1, 1); adv();
    run_to_idle(1, 1, 1, 1);
    drive(0, 16'd0, 0, 0, 0, 0, 0);
    chk("midstart_in_cnt", in_cnt_o, 4);
    adv();

`ifdef DEV_RESHUFFLER_CTRL_PERF_EN
    drive(1, 16'd2, 0, 1, 1, 1, 1); adv();
    run_to_idle(1, 1, 1, 1);
    drive(0, 16'd0, 0, 0, 0, 0, 0);
    chk("perf_len2", perf_cycles_o, 5);
    adv();
    drive(1, 16'd1, 0, 0, 0, 0, 0); adv();
    drive(0, 16'd0, 0, 0, 0, 0, 0);
    chk("perf_cleared", perf_cycles_o, 0);
    adv();
    run_to_idle(1, 1, 1, 1);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 7) == 0), 16'($urandom_range(0, 6)), ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      adv();
    end

    // Asynchronous reset in the middle of a job
    run_to_idle(1, 1, 1, 1);
    drive(1, 16'd6, 0, 1, 1, 1, 1); adv();
    drive(0, 16'd0, 0, 1, 1, 1, 1); adv();
    drive(0, 16'd0, 0, 1, 1, 1, 1);
    rst_n = 1'b0;
    #2;
    chk("async_reset", {busy_o, done_o, src_ready_o, dp_valid_o, dp_out_ready_o, dst_valid_o,
                        in_cnt_o, out_cnt_o}, 38'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drive(0, 16'd0, 0, 1, 1, 1, 1); adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
